// File: rtl/branch_predictor_pkg.sv
// Shared encodings and PC field geometry for the branch predictor slice.
// Pure declarations: no latency, no backpressure.
package branch_predictor_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t STRONG_NT = 2'b00;
    localparam ctr_t WEAK_NT   = 2'b01;
    localparam ctr_t WEAK_T    = 2'b10;
    localparam ctr_t STRONG_T  = 2'b11;

    localparam int PC_WIDTH        = 32;
    localparam int IDX_LSB         = 2;
    localparam int DEF_INDEX_WIDTH = 6;

    function automatic int tag_width(input int idx_w);
        return PC_WIDTH - idx_w - IDX_LSB;
    endfunction

endpackage

// File: rtl/saturating_counter_update.sv
// Next-state for a 2-bit direction counter; jumps snap straight to strong-taken.
// Combinational, 0-cycle; no backpressure.
module saturating_counter_update
    import branch_predictor_pkg::*;
(
    input  ctr_t cur_i,
    input  logic taken_i,
    input  logic is_conditional_i,
    output ctr_t next_o
);

    always_comb begin
        next_o = cur_i;
        if (taken_i) begin
            if (!is_conditional_i) begin
                next_o = STRONG_T;
            end else if (cur_i != STRONG_T) begin
                next_o = cur_i + 2'd1;
            end
        end else if (cur_i != STRONG_NT) begin
            next_o = cur_i - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB + 2-bit counters: 0-cycle lookup and resolve, tables/counters train on the edge.
// No backpressure: IF holds lookup_pc during stalls, EX qualifies updates with update_valid.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int INDEX_WIDTH = DEF_INDEX_WIDTH,
    parameter int TAG_WIDTH   = tag_width(DEF_INDEX_WIDTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] lookup_pc,
    output logic        predict_taken,
    output logic [31:0] predicted_next_pc,
    input  logic        update_valid,
    input  logic [31:0] update_pc,
    input  logic        update_is_conditional,
    input  logic        update_taken,
    input  logic [31:0] update_target,
    input  logic [31:0] update_predicted_next_pc,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
);

    localparam int ENTRIES = 1 << INDEX_WIDTH;
    localparam int TAG_LSB = INDEX_WIDTH + IDX_LSB;

    logic [ENTRIES-1:0]   valid_q;
    logic [TAG_WIDTH-1:0] tag_q    [ENTRIES];
    logic [31:0]          target_q [ENTRIES];
    ctr_t                 ctr_q    [ENTRIES];
    logic [31:0]          branch_count_q, mispredict_count_q;

    logic [INDEX_WIDTH-1:0] l_idx, u_idx;
    logic [TAG_WIDTH-1:0]   l_tag, u_tag;
    logic                   l_hit, u_hit;
    logic [31:0]            actual_next, update_seq_pc;
    ctr_t                   ctr_d, ctr_alloc;

    assign l_idx = lookup_pc[TAG_LSB-1:IDX_LSB];
    assign l_tag = lookup_pc[31:TAG_LSB];
    assign u_idx = update_pc[TAG_LSB-1:IDX_LSB];
    assign u_tag = update_pc[31:TAG_LSB];

    assign l_hit = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

    assign predict_taken     = l_hit && ctr_q[l_idx][1];
    assign predicted_next_pc = predict_taken ? target_q[l_idx] : lookup_pc + 32'd4;

    assign update_seq_pc = update_pc + 32'd4;
    assign actual_next   = update_taken ? update_target : update_seq_pc;
    assign mispredict    = update_valid && (actual_next != update_predicted_next_pc);
    assign redirect_pc   = update_valid ? actual_next : update_seq_pc;

    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

    saturating_counter_update u_ctr_upd (
        .cur_i            (ctr_q[u_idx]),
        .taken_i          (update_taken),
        .is_conditional_i (update_is_conditional),
        .next_o           (ctr_d)
    );

    // A freshly allocated conditional starts weak so one not-taken flips it.
    assign ctr_alloc = update_is_conditional ? WEAK_T : STRONG_T;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q            <= '0;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= WEAK_NT;
            end
        end else if (update_valid) begin
            branch_count_q <= branch_count_q + 32'd1;
            if (mispredict) begin
                mispredict_count_q <= mispredict_count_q + 32'd1;
            end
            if (update_taken) begin
                valid_q[u_idx] <= 1'b1;
                ctr_q[u_idx]   <= u_hit ? ctr_d : ctr_alloc;
            end else if (u_hit) begin
                ctr_q[u_idx] <= ctr_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && update_valid && update_taken) begin
            tag_q[u_idx]    <= u_tag;
            target_q[u_idx] <= update_target;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed scoreboard bench for branch_predictor: vectors push expectations, a negedge monitor pops and checks.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] lookup_pc;
    logic        predict_taken;
    logic [31:0] predicted_next_pc;
    logic        update_valid;
    logic [31:0] update_pc;
    logic        update_is_conditional;
    logic        update_taken;
    logic [31:0] update_target;
    logic [31:0] update_predicted_next_pc;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    branch_predictor dut (
        .clk                      (clk),
        .rst                      (rst),
        .lookup_pc                (lookup_pc),
        .predict_taken            (predict_taken),
        .predicted_next_pc        (predicted_next_pc),
        .update_valid             (update_valid),
        .update_pc                (update_pc),
        .update_is_conditional    (update_is_conditional),
        .update_taken             (update_taken),
        .update_target            (update_target),
        .update_predicted_next_pc (update_predicted_next_pc),
        .mispredict               (mispredict),
        .redirect_pc              (redirect_pc),
        .branch_count             (branch_count),
        .mispredict_count         (mispredict_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        pt;
        logic [31:0] pn;
        logic        mis;
        logic [31:0] rd;
        logic [31:0] bc;
        logic [31:0] mc;
    } exp_t;

    exp_t sb[$];
    logic obs_vld = 1'b0;
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s.%s got=0x%08h want=0x%08h", nm, fld, act, exp);
        end
    endtask

    // Monitor: consumes one expectation per observed cycle.
    always @(negedge clk) begin
        if (obs_vld) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard_underflow got=0 want=1");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk(e.name, "predict_taken", {31'd0, predict_taken}, {31'd0, e.pt});
                chk(e.name, "predicted_next_pc", predicted_next_pc, e.pn);
                chk(e.name, "mispredict", {31'd0, mispredict}, {31'd0, e.mis});
                chk(e.name, "redirect_pc", redirect_pc, e.rd);
                chk(e.name, "branch_count", branch_count, e.bc);
                chk(e.name, "mispredict_count", mispredict_count, e.mc);
            end
        end
    end

    // Called just after a rising edge; leaves one cycle for the monitor, ends just after the next edge.
    task automatic vec(input string nm, input logic r, input logic [31:0] lpc,
                       input logic uv, input logic [31:0] upc, input logic cond, input logic tk,
                       input logic [31:0] tgt, input logic [31:0] upred,
                       input logic e_pt, input logic [31:0] e_pn, input logic e_mis,
                       input logic [31:0] e_rd, input logic [31:0] e_bc, input logic [31:0] e_mc);
        exp_t e;
        rst                      = r;
        lookup_pc                = lpc;
        update_valid             = uv;
        update_pc                = upc;
        update_is_conditional    = cond;
        update_taken             = tk;
        update_target            = tgt;
        update_predicted_next_pc = upred;
        e.name = nm; e.pt = e_pt; e.pn = e_pn; e.mis = e_mis; e.rd = e_rd; e.bc = e_bc; e.mc = e_mc;
        sb.push_back(e);
        obs_vld = 1'b1;
        @(posedge clk);
        #1;
        obs_vld = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        lookup_pc = 32'h100;
        update_valid = 1'b0;
        update_pc = '0;
        update_is_conditional = 1'b0;
        update_taken = 1'b0;
        update_target = '0;
        update_predicted_next_pc = '0;
        @(posedge clk);
        #1;
        //   name         rst lpc          uv upc          cnd tk tgt     upred        pt pn           mis rd           bc   mc
        vec("reset",      1, 32'h100,      0, 32'h0,       0, 0, 32'h0,   32'h0,       0, 32'h104,     0, 32'h4,       0,   0);
        vec("train_tk",   0, 32'h100,      1, 32'h100,     1, 1, 32'h80,  32'h104,     0, 32'h104,     1, 32'h80,      0,   0);
        vec("trained",    0, 32'h100,      0, 32'h0,       0, 0, 32'h0,   32'h0,       1, 32'h80,      0, 32'h4,       1,   1);
        vec("nt1",        0, 32'h100,      1, 32'h100,     1, 0, 32'h80,  32'h80,      1, 32'h80,      1, 32'h104,     1,   1);
        vec("nt2",        0, 32'h100,      1, 32'h100,     1, 0, 32'h80,  32'h104,     0, 32'h104,     0, 32'h104,     2,   2);
        vec("nt3",        0, 32'h100,      1, 32'h100,     1, 0, 32'h80,  32'h104,     0, 32'h104,     0, 32'h104,     3,   2);
        vec("tk_from00",  0, 32'h100,      1, 32'h100,     1, 1, 32'h80,  32'h104,     0, 32'h104,     1, 32'h80,      4,   2);
        vec("ctr01",      0, 32'h100,      0, 32'h0,       0, 0, 32'h0,   32'h0,       0, 32'h104,     0, 32'h4,       5,   3);
        vec("to_wt",      0, 32'h100,      1, 32'h100,     1, 1, 32'h80,  32'h104,     0, 32'h104,     1, 32'h80,      5,   3);
        vec("alias_miss", 0, 32'h200,      0, 32'h0,       0, 0, 32'h0,   32'h0,       0, 32'h204,     0, 32'h4,       6,   4);
        vec("orig_hit",   0, 32'h100,      0, 32'h0,       0, 0, 32'h0,   32'h0,       1, 32'h80,      0, 32'h4,       6,   4);
        vec("jal_alloc",  0, 32'h200,      1, 32'h200,     0, 1, 32'h400, 32'h204,     0, 32'h204,     1, 32'h400,     6,   4);
        vec("jal_hit",    0, 32'h200,      0, 32'h0,       0, 0, 32'h0,   32'h0,       1, 32'h400,     0, 32'h4,       7,   5);
        vec("evicted",    0, 32'h100,      0, 32'h0,       0, 0, 32'h0,   32'h0,       0, 32'h104,     0, 32'h4,       7,   5);
        vec("realloc",    0, 32'h100,      1, 32'h100,     1, 1, 32'h80,  32'h104,     0, 32'h104,     1, 32'h80,      7,   5);
        vec("hazard_old", 0, 32'h100,      1, 32'h100,     1, 1, 32'h90,  32'h80,      1, 32'h80,      1, 32'h90,      8,   6);
        vec("hazard_new", 0, 32'h100,      1, 32'h100,     1, 1, 32'h90,  32'h90,      1, 32'h90,      0, 32'h90,      9,   7);
        vec("good_pred",  0, 32'h100,      0, 32'h0,       0, 0, 32'h0,   32'h0,       1, 32'h90,      0, 32'h4,       10,  7);
        vec("pc_wrap",    0, 32'hFFFFFFFC, 0, 32'hFFFFFFFC, 0, 0, 32'h0,  32'h0,       0, 32'h0,       0, 32'h0,       10,  7);
        vec("uv_low",     0, 32'h100,      0, 32'h100,     1, 1, 32'h44,  32'h0,       1, 32'h90,      0, 32'h104,     10,  7);
        vec("uv_low_chk", 0, 32'h100,      0, 32'h0,       0, 0, 32'h0,   32'h0,       1, 32'h90,      0, 32'h4,       10,  7);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        vec("rst_pulse",  0, 32'h100,      0, 32'h0,       0, 0, 32'h0,   32'h0,       0, 32'h104,     0, 32'h4,       0,   0);
        vec("retrain",    0, 32'h100,      1, 32'h100,     1, 1, 32'h90,  32'h104,     0, 32'h104,     1, 32'h90,      0,   0);
        vec("rst_w_upd",  1, 32'h100,      1, 32'h100,     1, 1, 32'h90,  32'h104,     0, 32'h104,     1, 32'h90,      0,   0);
        vec("upd_ignored",0, 32'h100,      0, 32'h0,       0, 0, 32'h0,   32'h0,       0, 32'h104,     0, 32'h4,       0,   0);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
Dynamic branch predictor and misprediction checker for the single-issue pipeline. IF queries it with the fetch PC to get a predicted next PC. EX feeds back the resolved outcome: the branch-unit condition result for conditional branches, or always-taken for JAL/JALR. From that it trains the tables and flags a redirect. It combines a direct-mapped BTB with 2-bit saturating counters and keeps two performance counters.

Parameters:
INDEX_WIDTH, 6, log2 of table entries (64 entries); PC bits [INDEX_WIDTH+1:2] form the index
TAG_WIDTH, 24, equals 32-INDEX_WIDTH-2; PC bits [31:INDEX_WIDTH+2] form the tag

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
lookup_pc  input  32  IF fetch PC
predict_taken  output  1  high when the BTB hits and counter[1]=1
predicted_next_pc  output  32  equals the stored target if predict_taken, else lookup_pc+4
update_valid  input  1  EX holds a resolved, non-flushed control-flow instruction
update_pc  input  32  PC of the resolved instruction
update_is_conditional  input  1  1 = Bxx, 0 = JAL/JALR
update_taken  input  1  actual direction (branch condition met, or 1 for jumps)
update_target  input  32  actual taken target
update_predicted_next_pc  input  32  predicted_next_pc carried down the pipe with the instruction
mispredict  output  1  redirect request to the PC/flush logic
redirect_pc  output  32  correct next PC
branch_count  output  32  resolved control-flow instructions since reset
mispredict_count  output  32  mispredictions since reset

Behaviour:
- Storage per entry: valid (1), tag, target (32), counter (2). Held in flops so reset can clear it. Asynchronous read.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Lookup (combinational, 0-cycle): hit = valid[idx] and tag matches.
  - predict_taken = hit and counter[1].
  - predicted_next_pc = predict_taken ? target : lookup_pc+4. The +4 wraps mod 2^32.
- Resolve (combinational, from the update_* inputs):
  - actual_next = update_taken ? update_target : update_pc+4.
  - mispredict = update_valid and (actual_next != update_predicted_next_pc).
  - redirect_pc = actual_next, driven whenever update_valid is high. It equals update_pc+4 when update_valid is low.
- Update (rising edge, when update_valid is high). Let uhit be the BTB hit for update_pc.
  - Taken and uhit: write target. Counter becomes 11 if unconditional, else increments and saturates at 11.
  - Taken and miss: allocate the entry, overwriting any alias: valid=1, write tag and target. Counter is 11 if unconditional, else 10.
  - Not taken and uhit: counter decrements and saturates at 00. Target is unchanged.
  - Not taken and miss: no table change.
  - branch_count increments by 1. mispredict_count increments by 1 if mispredict is high. Both wrap at 2^32.
- Simultaneous lookup and update to the same index: lookup returns pre-update state. There is no bypass; the new state is visible from the next cycle.
- update_valid low: no state change.
- X on update_* while update_valid is low must not corrupt state.
- Reset (asynchronous, any time including mid-update):
  - All valid bits go to 0 and all counters to 01.
  - branch_count and mispredict_count go to 0. Targets and tags need not be reset.
  - predict_taken goes to 0 and predicted_next_pc to lookup_pc+4, immediately.
  - mispredict goes to 0 only if update_valid is low; it stays combinational on its inputs.
- No stall input. IF holds lookup_pc stable during stalls, and the output follows it.

Decomposition:
- Shared package (branch_predictor_pkg): counter encoding constants (STRONG_NT, WEAK_NT, WEAK_T, STRONG_T), default INDEX_WIDTH, and the tag/index extraction widths.
- One natural sub-module: saturating_counter_update. It is combinational and takes the current 2-bit value, taken, and is_conditional, and returns the next 2-bit value.
- The tables stay in the top level as arrays.

Test Plan:
- Reset: assert rst, lookup_pc=0x100 -> predict_taken=0, predicted_next_pc=0x104, both counts 0.
- Taken conditional training: update_pc=0x100, taken=1, target=0x80, predicted 0x104.
  - Same cycle: mispredict=1, redirect_pc=0x80.
  - Next cycle: lookup 0x100 gives predict_taken=1 and next 0x80; mispredict_count=1, branch_count=1.
- Hysteresis and saturation: from counter 10 at 0x100, apply three not-taken updates.
  - After the 1st: lookup gives 0x104 (counter 01).
  - After the 3rd: counter stays at 00.
  - One taken update then gives 01; still predicts 0x104.
- Alias replacement: train 0x100 taken to 0x80, then lookup 0x200 (same index, different tag) -> miss, 0x204.
  - Taken JAL update at 0x200 to 0x400 -> lookup 0x200 gives 0x400 (counter 11); lookup 0x100 now misses.
- Same-cycle hazard: lookup 0x100 while updating 0x100 taken to 0x90 -> this cycle shows the old prediction, next cycle shows 0x90.
  - A correctly predicted update gives mispredict=0 and leaves mispredict_count unchanged.
- Mid-run reset: with the table trained, pulse rst between edges.
  - Outputs drop immediately to not-taken/pc+4 and counts to 0.
  - An update_valid edge coincident with rst is ignored.
